// File: rtl/seq_div8.sv
// seq_div8: 8-bit restoring divider, 8 iterations per op; SEQ_DIV8_ZERO_DETECT_EN adds 1-cycle divide-by-zero completion
module seq_div8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, q_q, q_d, m_q, m_d, quo_q, quo_d, rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d, dz_q, dz_d, zero_skip;
  logic [8:0] sh, t;
  // The partial remainder always stays below the divisor, so its ninth bit is zero after every iteration and need not be stored.
  assign sh = {a_q, q_q[7]};
  assign t  = sh - {1'b0, m_q};
`ifdef SEQ_DIV8_ZERO_DETECT_EN
  assign zero_skip = divisor == 8'd0;
`else
  assign zero_skip = 1'b0;
`endif
  // Next state: load operands on start, otherwise one shift-and-subtract step per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    if (state_q == IDLE) begin
      if (start && zero_skip) begin
        quo_d  = 8'hFF;
        rem_d  = dividend;
        done_d = 1'b1;
        dz_d   = 1'b1;
      end else if (start) begin
        a_d     = 8'd0;
        q_d     = dividend;
        m_d     = divisor;
        cnt_d   = 3'd0;
        state_d = RUN;
      end
    end else begin
      a_d   = t[8] ? sh[7:0] : t[7:0];
      q_d   = {q_q[6:0], ~t[8]};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        quo_d   = q_d;
        rem_d   = a_d;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  // State and result registers; reset aborts any operation and clears all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      q_q     <= 8'd0;
      m_q     <= 8'd0;
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 8'd0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = state_q == RUN;
  assign done      = done_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: vector table, hand corner sequences and random ops checked against arithmetic division
module tb_seq_div8;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] dividend = 8'd0, divisor = 8'd0;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_zero;
  int checks = 0, errors = 0;

  seq_div8 dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd, dv, eq, er;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic op(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                    input logic [7:0] er, input string nm);
    int n, nb, el;
    logic ez;
    el = 8;
    ez = 1'b0;
`ifdef SEQ_DIV8_ZERO_DETECT_EN
    if (dv == 8'd0) begin
      el = 0;
      ez = 1'b1;
    end
`endif
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n  = 0;
    nb = 0;
    while (!done && n < 20) begin
      nb += int'(busy);
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, el);
    chk({nm, " busy_cycles"}, nb, el);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_zero"}, div_zero, ez);
    chk({nm, " busy_at_done"}, busy, 0);
  endtask

  task automatic after_done(input string nm, input logic [7:0] eq, input logic [7:0] er);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " div_zero_clear"}, div_zero, 0);
    chk({nm, " quotient_hold"}, quotient, eq);
    chk({nm, " remainder_hold"}, remainder, er);
  endtask

  initial begin
    vec_t vt[6];
    int n, nd;
    logic [7:0] dd, dv, eq, er;
    vt[0] = '{8'd200, 8'd7,   8'd28,  8'd4};
    vt[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
    vt[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
    vt[3] = '{8'd0,   8'd13,  8'd0,   8'd0};
    vt[4] = '{8'd255, 8'd255, 8'd1,   8'd0};
    vt[5] = '{8'h5A,  8'd0,   8'hFF,  8'h5A};

    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_zero", div_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      op(vt[i].dd, vt[i].dv, vt[i].eq, vt[i].er, $sformatf("vec%0d", i));
      after_done($sformatf("vec%0d", i), vt[i].eq, vt[i].er);
    end

    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ignore busy_before_second", busy, 1);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignore latency", n, 8);
    chk("ignore quotient", quotient, 33);
    chk("ignore remainder", remainder, 1);
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("ignore no_second_done", nd, 0);

    op(8'd100, 8'd3, 8'd33, 8'd1, "b2b_first");
    op(8'd50, 8'd5, 8'd10, 8'd0, "b2b_second");
    after_done("b2b", 8'd10, 8'd0);

    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort div_zero", div_zero, 0);
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      nd += int'(done) + int'(busy);
    end
    chk("abort stays_idle", nd, 0);
    op(8'd200, 8'd7, 8'd28, 8'd4, "after_abort");

    for (int i = 0; i < 40; i++) begin
      dd = 8'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      eq = (dv == 8'd0) ? 8'hFF : dd / dv;
      er = (dv == 8'd0) ? dd : dd % dv;
      op(dd, dv, eq, er, $sformatf("rand%0d", i));
      if (dv != 8'd0) chk($sformatf("rand%0d invariant", i), 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
      if ($urandom_range(0, 1) == 1) after_done($sformatf("rand%0d", i), eq, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
